// File: rtl/mac_accum.sv
// Signed multiply-accumulate stage: registered operands feed a combinational
// array multiplier whose products are summed into a saturating accumulator.

module array_mult #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0]   A,
  input  logic [SIZE-1:0]   B,
  output logic [2*SIZE-1:0] P
);

  logic [2*SIZE-1:0] a_ext;

  assign a_ext = {{SIZE{A[SIZE-1]}}, A};

  // One adder row per multiplier bit; the MSB of B carries negative weight,
  // so its row is subtracted rather than added.
  for (genvar i = 0; i < SIZE; i++) begin : g_row
    logic [2*SIZE-1:0] pp;
    logic [2*SIZE-1:0] sum;

    assign pp = (a_ext & {(2*SIZE){B[i]}}) << i;

    if (i == 0) begin : g_first
      assign sum = pp;
    end else if (i == SIZE-1) begin : g_sign
      assign sum = g_row[i-1].sum - pp;
    end else begin : g_mid
      assign sum = g_row[i-1].sum + pp;
    end
  end

  assign P = g_row[SIZE-1].sum;

endmodule

module mac_accum #(
  parameter int SIZE  = 8,
  parameter int ACC_W = 2*SIZE+4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  a,
  input  logic [SIZE-1:0]  b,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic [SIZE-1:0]   a_q;
  logic [SIZE-1:0]   b_q;
  logic              p_vld;
  logic [CNT_W-1:0]  rem;
  logic [2*SIZE-1:0] prod;
  logic [ACC_W-1:0]  acc;
  logic              ovf_q;
  logic              start_ok;
  logic              accept;
  logic [ACC_W:0]    sum;
  logic              sum_ovf;
  logic [ACC_W-1:0]  acc_nxt;

  array_mult #(.SIZE(SIZE)) u_mult (
    .A (a_q),
    .B (b_q),
    .P (prod)
  );

  assign start_ok = (state == S_IDLE) && start;
  assign accept   = (state == S_ACCUM) && in_valid;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      // A zero-term request still passes through DRAIN so the result appears
      // one cycle later, matching the non-empty case's fixed drain latency.
      S_IDLE:  if (start) state_nxt = (count == '0) ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (in_valid && rem == CNT_W'(1)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE:  busy      = 1'b0;
      S_ACCUM: in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Sum one bit wider than the accumulator; the top two bits disagreeing
  // means the true result lies outside the signed ACC_W range.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} +
              {{(ACC_W+1-2*SIZE){prod[2*SIZE-1]}}, prod};
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    acc_nxt = sum[ACC_W-1:0];
    if (sum_ovf) acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_vld <= 1'b0;
      rem   <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        rem <= rem - CNT_W'(1);
      end
      if (start_ok) begin
        acc   <= '0;
        ovf_q <= 1'b0;
        rem   <= count;
      end else if (p_vld) begin
        acc <= acc_nxt;
        if (sum_ovf) ovf_q <= 1'b1;
      end
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_q;

endmodule
